// File: rtl/alu_op_sequencer.sv
// Four-cycle ALU sequencer: accept, read operands, execute, write back. instr_ready is high only in IDLE.
// Build option: define ALU_SEQ_CMP_EN to make opcode 110 a compare (SUB that updates flags but skips writeback).
module alu_op_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [2:0]  opcode,
  input  logic [2:0]  rd,
  input  logic [2:0]  rs,
  input  logic        ld_en,
  input  logic [2:0]  ld_addr,
  input  logic [15:0] ld_data,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_sel,
  output logic        alu_cin,
  input  logic [15:0] alu_r,
  input  logic        alu_c,
  input  logic        alu_z,
  output logic        flag_c,
  output logic        flag_z,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_EXEC = 3'd2;
  localparam logic [2:0] S_WB   = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_CMP = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

`ifdef ALU_SEQ_CMP_EN
  localparam logic CMP_EN = 1'b1;
`else
  localparam logic CMP_EN = 1'b0;
`endif

  logic [2:0]  state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [2:0]  rd_q, rd_d;
  logic [2:0]  rs_q, rs_d;
  logic [15:0] op_a_q, op_a_d;
  logic [15:0] op_b_q, op_b_d;
  logic [15:0] res_q, res_d;
  logic        res_c_q, res_c_d;
  logic        res_z_q, res_z_d;
  logic        flag_c_q, flag_c_d;
  logic        flag_z_q, flag_z_d;
  logic [15:0] rf_q [8];
  logic [15:0] rf_d [8];

  logic hs;
  logic op_legal;
  logic is_cmp;

  // Ready is forced low while reset is asserted so nothing is accepted on the reset edge.
  assign instr_ready = rst_n & (state_q == S_IDLE);
  assign hs          = instr_valid & instr_ready;
  assign op_legal    = (opcode != OP_ILL) && (CMP_EN || (opcode != OP_CMP));
  assign is_cmp      = CMP_EN && (op_q == OP_CMP);

  assign alu_a    = op_a_q;
  assign alu_b    = op_b_q;
  assign alu_sel  = is_cmp ? OP_SUB : op_q;
  assign alu_cin  = flag_c_q;
  assign flag_c   = flag_c_q;
  assign flag_z   = flag_z_q;
  assign done     = rst_n & (state_q == S_WB);
  assign err      = rst_n & (state_q == S_ERR);
  assign dbg_data = rf_q[dbg_addr];

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    rs_d     = rs_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    res_d    = res_q;
    res_c_d  = res_c_q;
    res_z_d  = res_z_q;
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    rf_d     = rf_q;

    case (state_q)
      S_IDLE: begin
        // A handshake takes priority; a same-cycle load is dropped.
        if (hs) begin
          op_d    = opcode;
          rd_d    = rd;
          rs_d    = rs;
          state_d = op_legal ? S_READ : S_ERR;
        end else if (ld_en) begin
          rf_d[ld_addr] = ld_data;
        end
      end
      S_READ: begin
        op_a_d  = rf_q[rd_q];
        op_b_d  = rf_q[rs_q];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d   = alu_r;
        res_c_d = alu_c;
        res_z_d = alu_z;
        state_d = S_WB;
      end
      S_WB: begin
        if (!is_cmp) begin
          rf_d[rd_q] = res_q;
        end
        flag_c_d = res_c_q;
        flag_z_d = res_z_q;
        state_d  = S_IDLE;
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= 3'd0;
      rd_q     <= 3'd0;
      rs_q     <= 3'd0;
      op_a_q   <= 16'h0000;
      op_b_q   <= 16'h0000;
      res_q    <= 16'h0000;
      res_c_q  <= 1'b0;
      res_z_q  <= 1'b0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        rf_q[i] <= 16'h0000;
      end
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rs_q     <= rs_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      res_q    <= res_d;
      res_c_q  <= res_c_d;
      res_z_q  <= res_z_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
      for (int i = 0; i < 8; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU, directed instructions, scoreboard of expected completions.
module tb_alu_op_sequencer;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  opcode;
  logic [2:0]  rd;
  logic [2:0]  rs;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_sel;
  logic        alu_cin;
  logic [15:0] alu_r;
  logic        alu_c;
  logic        alu_z;
  logic        flag_c;
  logic        flag_z;
  logic        done;
  logic        err;

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .rd(rd), .rs(rs),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
    .alu_r(alu_r), .alu_c(alu_c), .alu_z(alu_z),
    .flag_c(flag_c), .flag_z(flag_z), .done(done), .err(err)
  );

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_INCR = 3'b010;
  localparam logic [2:0] OP_DECR = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_RRC  = 3'b101;
  localparam logic [2:0] OP_CMP  = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  // Reference ALU: ADD and RRC consume carry-in, SUB/DECR report borrow in C.
  logic [16:0] alu_t;
  always_comb begin
    alu_t = {1'b0, alu_a};
    case (alu_sel)
      OP_ADD:  alu_t = {1'b0, alu_a} + {1'b0, alu_b} + {16'h0000, alu_cin};
      OP_SUB:  alu_t = {1'b0, alu_a} - {1'b0, alu_b};
      OP_INCR: alu_t = {1'b0, alu_a} + 17'd1;
      OP_DECR: alu_t = {1'b0, alu_a} - 17'd1;
      OP_SHL:  alu_t = {alu_a, 1'b0};
      OP_RRC:  alu_t = {alu_a[0], alu_cin, alu_a[15:1]};
      default: alu_t = {1'b0, alu_a};
    endcase
  end
  assign alu_r = alu_t[15:0];
  assign alu_c = alu_t[16];
  assign alu_z = (alu_t[15:0] == 16'h0000);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_err;
    logic [2:0]  rd;
    logic [15:0] val;
    logic        c;
    logic        z;
  } exp_t;

  exp_t sb[$];
  int   acc_q[$];
  exp_t pend_e;
  logic pend;
  int   checks;
  int   errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever done/err is presented, checks the commit one cycle later.
  initial begin
    int   cyc;
    int   a;
    exp_t e;
    cyc  = 0;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (pend) begin
        chk(pend_e.is_err ? "err_reg_kept" : "wb_reg", {16'h0, dbg_data}, {16'h0, pend_e.val});
        chk("flag_c_after", {31'h0, flag_c}, {31'h0, pend_e.c});
        chk("flag_z_after", {31'h0, flag_z}, {31'h0, pend_e.z});
        chk("ready_after", {31'h0, instr_ready}, 32'd1);
        pend = 1'b0;
      end
      if (instr_valid && instr_ready) acc_q.push_back(cyc);
      if (done || err) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: done=%0b err=%0b with nothing outstanding", done, err);
        end else begin
          e = sb.pop_front();
          chk("pulse_kind", {30'h0, err, done}, {30'h0, e.is_err, ~e.is_err});
          if (acc_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL latency: pulse with no recorded accept");
          end else begin
            a = acc_q.pop_front();
            chk("latency", cyc - a, e.is_err ? 32'd1 : 32'd3);
          end
          pend_e = e;
          pend   = 1'b1;
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!instr_ready && n < 50) begin
      step();
      n++;
    end
    if (!instr_ready) begin
      checks++;
      errors++;
      $display("FAIL wait_ready: instr_ready never rose, got %0b want 1", instr_ready);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || pend) && n < 60) begin
      step();
      n++;
      if (instr_ready) ld_en = 1'b0;
    end
    ld_en = 1'b0;
    if (sb.size() != 0 || pend) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d completions still outstanding, want 0", sb.size());
    end
  endtask

  task automatic load(input logic [2:0] a, input logic [15:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    step();
    ld_en   = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] r_d, input logic [2:0] r_s,
                       input logic e_err, input logic [15:0] e_val, input logic e_c,
                       input logic e_z, input logic ld_hold);
    exp_t       e;
    logic [2:0] e_sel;
    e.is_err = e_err;
    e.rd     = r_d;
    e.val    = e_val;
    e.c      = e_c;
    e.z      = e_z;
    e_sel    = op;
`ifdef ALU_SEQ_CMP_EN
    if (op == OP_CMP) e_sel = OP_SUB;
`endif
    wait_ready();
    sb.push_back(e);
    instr_valid = 1'b1;
    opcode      = op;
    rd          = r_d;
    rs          = r_s;
    dbg_addr    = r_d;
    if (ld_hold) begin
      ld_en   = 1'b1;
      ld_addr = 3'd7;
      ld_data = 16'hDEAD;
    end
    step();
    instr_valid = 1'b0;
    chk("alu_sel", {29'h0, alu_sel}, {29'h0, e_sel});
    drain();
  endtask

  initial begin
    exp_t e;
    int   n;
    int   pulses;
    checks = 0;
    errors = 0;
    rst_n = 1'b0; instr_valid = 1'b0; opcode = 3'd0; rd = 3'd0; rs = 3'd0;
    ld_en = 1'b0; ld_addr = 3'd0; ld_data = 16'h0; dbg_addr = 3'd0;
    step();
    step();
    chk("ready_in_reset", {31'h0, instr_ready}, 32'd0);
    chk("done_in_reset", {31'h0, done}, 32'd0);
    chk("err_in_reset", {31'h0, err}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", {31'h0, instr_ready}, 32'd1);
    chk("flags_after_reset", {30'h0, flag_c, flag_z}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk("reg_reset", {16'h0, dbg_data}, 32'd0);
    end
    step();

    load(3'd1, 16'hFFFF); load(3'd2, 16'h0001); load(3'd3, 16'h0005);
    load(3'd4, 16'h0007); load(3'd5, 16'h0002); load(3'd6, 16'h1234);
    load(3'd7, 16'h1234);
    dbg_addr = 3'd4;
    #1;
    chk("load_r4", {16'h0, dbg_data}, 32'h0007);

    issue(OP_ADD, 3'd1, 3'd2, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    issue(OP_ILL, 3'd2, 3'd1, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0);
    issue(OP_SUB, 3'd3, 3'd4, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0);
    chk("alu_cin_chain", {31'h0, alu_cin}, 32'd1);
    issue(OP_RRC, 3'd5, 3'd0, 1'b0, 16'h8001, 1'b0, 1'b0, 1'b0);
`ifdef ALU_SEQ_CMP_EN
    issue(OP_CMP, 3'd6, 3'd7, 1'b0, 16'h1234, 1'b0, 1'b1, 1'b0);
`else
    issue(OP_CMP, 3'd6, 3'd7, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
`endif

    // Three INCR R0 with instr_valid held high throughout.
    for (int k = 1; k <= 3; k++) begin
      e.is_err = 1'b0; e.rd = 3'd0; e.val = 16'(k); e.c = 1'b0; e.z = 1'b0;
      sb.push_back(e);
    end
    instr_valid = 1'b1; opcode = OP_INCR; rd = 3'd0; rs = 3'd0; dbg_addr = 3'd0;
    wait_ready();
    step();
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (!instr_ready && n < 20) begin
        step();
        n++;
      end
      chk("b2b_gap", n, 32'd3);
      step();
    end
    instr_valid = 1'b0;
    drain();

    // Load held through accept and busy cycles must never land in R7.
    issue(OP_SHL, 3'd4, 3'd4, 1'b0, 16'h000E, 1'b0, 1'b0, 1'b1);
    dbg_addr = 3'd7;
    #1;
    chk("busy_load_ignored", {16'h0, dbg_data}, 32'h1234);
    issue(OP_DECR, 3'd2, 3'd2, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);

    // Reset during EXEC of ADD R1=0x0010 + R2=0x0001.
    load(3'd1, 16'h0010);
    load(3'd2, 16'h0001);
    dbg_addr = 3'd1;
    instr_valid = 1'b1; opcode = OP_ADD; rd = 3'd1; rs = 3'd2;
    step();
    instr_valid = 1'b0;
    step();
    rst_n = 1'b0;
    sb.delete();
    acc_q.delete();
    step();
    chk("ready_low_in_reset", {31'h0, instr_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_abort", {31'h0, instr_ready}, 32'd1);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (done || err) pulses++;
    end
    chk("no_done_after_abort", pulses, 32'd0);
    chk("flags_after_abort", {30'h0, flag_c, flag_z}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk("reg_after_abort", {16'h0, dbg_data}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Multi-cycle control sequencer that drives the combinational 16-bit ALU and consumes its result and flags. It accepts one ALU instruction at a time over a valid/ready handshake, reads operands from an internal 8×16 register file, and issues the 3-bit operation select plus carry-in to the ALU. It then captures R/C/Z, writes the result back and updates the flag register. It sits between instruction decode and the ALU in the CISC datapath.

## Interface
- No parameters; widths fixed: data 16, register address 3, ALU select 3.
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- instr_valid  in  1  instruction offered
- instr_ready  out  1  sequencer can accept (high only in IDLE)
- opcode  in  3  000 ADD, 001 SUB, 010 INCR, 011 DECR, 100 SHL, 101 RRC, 110 CMP/illegal, 111 illegal
- rd  in  3  destination and A-operand register
- rs  in  3  B-operand register
- ld_en  in  1  external register load (honoured only in IDLE)
- ld_addr  in  3  load address
- ld_data  in  16  load data
- dbg_addr  in  3  debug read address
- dbg_data  out  16  combinational read of reg[dbg_addr]
- alu_a  out  16  ALU operand A
- alu_b  out  16  ALU operand B
- alu_sel  out  3  ALU operation select
- alu_cin  out  1  ALU carry-in (equals flag_c)
- alu_r  in  16  ALU result
- alu_c  in  1  ALU carry/borrow out
- alu_z  in  1  ALU zero out
- flag_c  out  1  registered carry flag
- flag_z  out  1  registered zero flag
- done  out  1  one-cycle pulse on writeback/flag commit
- err  out  1  one-cycle pulse on illegal opcode

## Operation
- FSM states: IDLE, READ, EXEC, WB, ERR.
- IDLE:
  - instr_ready=1.
  - Handshake on instr_valid & instr_ready: latch opcode, rd, rs.
  - Legal opcode → READ. Illegal opcode → ERR.
  - When ld_en=1 and no handshake occurs: reg[ld_addr] ← ld_data.
  - When ld_en=1 and a handshake occurs in the same cycle: the handshake wins and the load is dropped.
- READ: op_a ← reg[rd], op_b ← reg[rs] → EXEC.
- EXEC:
  - alu_a=op_a, alu_b=op_b, alu_sel=latched opcode (CMP drives 001).
  - res ← alu_r, res_c ← alu_c, res_z ← alu_z → WB.
- WB:
  - reg[rd] ← res, except for CMP.
  - flag_c ← res_c, flag_z ← res_z.
  - done=1 → IDLE.
- ERR: err=1; registers and flags unchanged → IDLE.
- alu_a, alu_b and alu_sel are driven from the operand/opcode registers in every state. The ALU's output is sampled only in EXEC.
- alu_cin = flag_c, so consecutive RRC/ADD instructions chain through the carry.
- rd == rs is legal; both operands read the same value.
- ld_en outside IDLE is ignored.

## Timing
- Reset (rst_n low at a clock edge):
  - state=IDLE.
  - All 8 registers = 0x0000; op_a, op_b, res = 0.
  - flag_c = flag_z = 0; done = err = 0.
  - instr_ready = 0 while rst_n is low.
- Reset mid-instruction aborts it: no writeback, no done.
- Accept edge = cycle 0; READ cycle 1; EXEC cycle 2; WB/done cycle 3. New acceptance is possible at cycle 4 edge.
  - Throughput: 1 instruction per 4 cycles.
- Illegal opcode: err high in cycle 1; instr_ready high again in cycle 2.
- flag_c and flag_z change only on the clock edge ending WB.
- Updated register contents are visible on dbg_data from cycle 4.

## Configuration
- ALU_SEQ_CMP_EN defined:
  - Opcode 110 = CMP: computes rd − rs through the ALU and updates flag_c/flag_z.
  - No register write; done pulses.
- ALU_SEQ_CMP_EN undefined: opcode 110 is illegal (err pulse, no state change).
- Opcode 111 is always illegal.

## Test plan
- ADD carry/zero: load R1=0xFFFF, R2=0x0001; ADD rd=1, rs=2 → done at cycle 3, R1=0x0000, flag_c=1, flag_z=1.
- SUB borrow: R3=0x0005, R4=0x0007; SUB rd=3, rs=4 → R3=0xFFFE, flag_c=1, flag_z=0.
- RRC chaining: flag_c=1 from prior op, R5=0x0002; RRC rd=5 → alu_cin=1, R5=0x8001, flag_c=0.
- CMP build-dependent:
  - With ALU_SEQ_CMP_EN: R6=R7=0x1234, opcode 110 → R6 unchanged, flag_z=1, flag_c=0, done=1.
  - Without ALU_SEQ_CMP_EN: same stimulus → err at cycle 1, flags unchanged, no done.
- Handshake/load interactions:
  - instr_valid held high with back-to-back INCR R0 ×3 from 0x0000 → accepts every 4 cycles, R0=0x0003.
  - ld_en during READ/EXEC/WB → ignored.
- Reset mid-op: rst_n low during EXEC of ADD R1=0x0010 + R2=0x0001 → all registers 0x0000, flags 0, no done, instr_ready=1 the cycle after release.
